matmul_sequencer: RTL and testbench

Sequences one 2x2 × 2x2 matrix multiply over the existing 4-bit element selectors. It steps the selector entry codes for matrix A and matrix B through the eight partial-product terms and multiply-accumulates the returned elements. It writes the four 9-bit results into a packed result register and signals completion with a start/busy/done handshake. It sits between the top-level control and two element-selector instances, one for A and one for B; the packed 16-bit matrices feed those selectors directly, not this block.

---
 rtl/matmul_pkg.sv | 19 +
 rtl/matmul_mac.sv | 29 ++
 rtl/matmul_sequencer.sv | 88 ++++++++
 tb/tb_matmul_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared widths, FSM states and entry-code mapping for the 2x2 matrix sequencer.
// MATMUL_SIGNED_EN (see matmul_mac) switches element arithmetic to two's complement.
package matmul_pkg;

    localparam int ELEM_W = 4;
    localparam int RES_W  = 9;
    localparam int TERMS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic logic [2:0] entry_code(input logic [1:0] e);
        return {e[1], 1'b0, e[0]};
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate for one partial-product term of the 2x2 product.
// MATMUL_SIGNED_EN: sign-extend elements; otherwise they are zero-extended.
import matmul_pkg::*;

module matmul_mac (
    input  logic [ELEM_W-1:0] element_a,
    input  logic [ELEM_W-1:0] element_b,
    input  logic              clear,
    input  logic [RES_W-1:0]  acc,
    output logic [RES_W-1:0]  acc_next
);

    logic [RES_W-1:0] ext_a;
    logic [RES_W-1:0] ext_b;
    logic [RES_W-1:0] prod;

`ifdef MATMUL_SIGNED_EN
    assign ext_a = {{(RES_W-ELEM_W){element_a[ELEM_W-1]}}, element_a};
    assign ext_b = {{(RES_W-ELEM_W){element_b[ELEM_W-1]}}, element_b};
`else
    assign ext_a = {{(RES_W-ELEM_W){1'b0}}, element_a};
    assign ext_b = {{(RES_W-ELEM_W){1'b0}}, element_b};
`endif

    // Low RES_W bits of the product are exact in both encodings.
    assign prod     = ext_a * ext_b;
    assign acc_next = (clear ? '0 : acc) + prod;

endmodule

// File: rtl/matmul_sequencer.sv
// Steps the A/B selector entry codes through eight terms and packs C = A x B.
// Signed element arithmetic is selected by MATMUL_SIGNED_EN inside matmul_mac.
import matmul_pkg::*;

module matmul_sequencer (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hold,
    output logic [2:0]          entry_a,
    output logic [2:0]          entry_b,
    input  logic [ELEM_W-1:0]   element_a,
    input  logic [ELEM_W-1:0]   element_b,
    output logic [4*RES_W-1:0]  matrixC,
    output logic                busy,
    output logic                done
);

    state_t           state;
    logic [2:0]       t;
    logic [2:0]       t_nxt;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_next;

    assign t_nxt = t + 3'd1;

    matmul_mac u_mac (
        .element_a (element_a),
        .element_b (element_b),
        .clear     (~t[0]),
        .acc       (acc),
        .acc_next  (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            acc     <= '0;
            entry_a <= '0;
            entry_b <= '0;
            matrixC <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        t       <= '0;
                        acc     <= '0;
                        matrixC <= '0;
                        entry_a <= entry_code(2'b00);
                        entry_b <= entry_code(2'b00);
                        busy    <= 1'b1;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    if (!hold) begin
                        acc <= acc_next;
                        // k==1 closes the dot product for C[i][j]
                        if (t[0]) begin
                            for (int e = 0; e < 4; e++) begin
                                if (e[1:0] == {t[2], t[1]})
                                    matrixC[RES_W*e +: RES_W] <= acc_next;
                            end
                        end
                        if (t == 3'(TERMS-1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            t       <= t_nxt;
                            entry_a <= entry_code({t_nxt[2], t_nxt[0]});
                            entry_b <= entry_code({t_nxt[0], t_nxt[1]});
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer with behavioural A/B element selectors.
// Expected matrices come from constants or an independent integer matrix model.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [2:0]  entry_a;
    logic [2:0]  entry_b;
    logic [3:0]  element_a;
    logic [3:0]  element_b;
    logic [35:0] matrixC;
    logic        busy;
    logic        done;

    logic [15:0] a_mat = '0;
    logic [15:0] b_mat = '0;

    int checks = 0;
    int errors = 0;
    logic [35:0] sb[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [35:0] c;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .entry_a   (entry_a),
        .entry_b   (entry_b),
        .element_a (element_a),
        .element_b (element_b),
        .matrixC   (matrixC),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [3:0] sel(logic [15:0] m, logic [2:0] code);
        int idx;
        idx = 2 * int'(code[2]) + int'(code[0]);
        return m[4*idx +: 4];
    endfunction

    assign element_a = sel(a_mat, entry_a);
    assign element_b = sel(b_mat, entry_b);

    function automatic logic [35:0] pack4(int c00, int c01, int c10, int c11);
        logic [8:0] p0, p1, p2, p3;
        p0 = 9'(c00); p1 = 9'(c01); p2 = 9'(c10); p3 = 9'(c11);
        return {p3, p2, p1, p0};
    endfunction

    function automatic int el(logic [15:0] m, int e);
        logic [3:0] v;
        v = m[4*e +: 4];
`ifdef MATMUL_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [35:0] ref_mm(logic [15:0] a, logic [15:0] b);
        int s;
        logic [35:0] r;
        r = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += el(a, 2*i+k) * el(b, 2*k+j);
                r[9*(2*i+j) +: 9] = 9'(s);
            end
        return r;
    endfunction

    task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one multiply; optionally hold, stray start in ACC, start at done.
    task automatic run_mm(input logic [15:0] a, input logic [15:0] b,
                          input logic [35:0] exp, input int hold_at,
                          input int hold_len, input int stray_at,
                          input bit drop_start, input bit seq);
        int n;
        bit seen;
        logic [2:0] ea_exp[8];
        logic [2:0] eb_exp[8];
        logic [35:0] got;
        ea_exp = '{0, 1, 0, 1, 4, 5, 4, 5};
        eb_exp = '{0, 4, 1, 5, 0, 4, 1, 5};
        a_mat = a;
        b_mat = b;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb.push_back(exp);
        chk("busy_after_start", {35'd0, busy}, 36'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (seq && n < 8) begin
                chk($sformatf("entry_a_t%0d", n), {33'd0, entry_a}, {33'd0, ea_exp[n]});
                chk($sformatf("entry_b_t%0d", n), {33'd0, entry_b}, {33'd0, eb_exp[n]});
            end
            hold = (hold_at >= 0 && n >= hold_at && n < hold_at + hold_len);
            start = (n == stray_at);
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        hold = 1'b0;
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
            sb.delete();
        end else begin
            chk("latency", 36'(n), 36'(8 + hold_len));
            chk("busy_at_done", {35'd0, busy}, 36'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: done with empty queue");
            end else begin
                got = sb.pop_front();
                chk("matrixC", matrixC, got);
            end
            start = drop_start;
            @(negedge clk);
            start = 1'b0;
            chk("idle_after_done", {34'd0, busy, done}, 36'd0);
            chk("matrixC_hold", matrixC, exp);
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{16'h1001, 16'h4321, pack4(1, 2, 3, 4)};
        tbl[1] = '{16'h4321, 16'h4321, pack4(7, 10, 15, 22)};
        tbl[2] = '{16'h8888, 16'h8888, pack4(128, 128, 128, 128)};
        tbl[3] = '{16'h0000, 16'h5A3C, 36'd0};
`ifdef MATMUL_SIGNED_EN
        tbl[4] = '{16'hFFFF, 16'hFFFF, pack4(2, 2, 2, 2)};
`else
        tbl[4] = '{16'hFFFF, 16'hFFFF, pack4(450, 450, 450, 450)};
`endif
        for (int i = 5; i < 8; i++) begin
            tbl[i].a = 16'($urandom);
            tbl[i].b = 16'($urandom);
            tbl[i].c = ref_mm(tbl[i].a, tbl[i].b);
        end

        #12;
        chk("reset_ctl", {28'd0, entry_a, entry_b, busy, done}, 36'd0);
        chk("reset_matrixC", matrixC, 36'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_mm(tbl[i].a, tbl[i].b, tbl[i].c, -1, 0, -1, 1'b0, i == 1);

        // Stall three cycles at t=3 with a stray start in ACC.
        run_mm(16'h4321, 16'h4321, pack4(7, 10, 15, 22), 3, 3, 5, 1'b0, 1'b0);

        // A start that coincides with done is dropped.
        run_mm(16'h1001, 16'h4321, pack4(1, 2, 3, 4), -1, 0, -1, 1'b1, 1'b0);

        // Asynchronous reset at t=5 aborts the run.
        a_mat = 16'h4321;
        b_mat = 16'h4321;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 5) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        chk("midreset_ctl", {28'd0, entry_a, entry_b, busy, done}, 36'd0);
        chk("midreset_matrixC", matrixC, 36'd0);
        @(negedge clk);
        rst = 1'b0;
        run_mm(16'h4321, 16'h4321, pack4(7, 10, 15, 22), -1, 0, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
